game_round_sequencer: RTL and testbench

- Top-level round controller for the 4-square colour-matching game.
- Drives the shared `step` bus and the target square (`variety`) consumed by the per-step cursor datapaths (step3, etc.).
- Times each phase, judges the player's confirm against the cursor, and keeps score, round and lives.
- Sits between the button front end and the square/VGA datapaths.

---
 rtl/game_pkg.sv | 25 ++
 rtl/game_lfsr.sv | 22 ++
 rtl/game_round_sequencer.sv | 170 +++++++++++++++++
 tb/tb_game_round_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants for the colour-matching game: phase encodings on the step bus,
// square identifiers and the target-selection LFSR definition.
package game_pkg;

    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_LOAD   = 3'b001;
    localparam logic [2:0] ST_SHOW   = 3'b010;
    localparam logic [2:0] ST_PLAY   = 3'b011;
    localparam logic [2:0] ST_RESULT = 3'b100;
    localparam logic [2:0] ST_OVER   = 3'b101;

    localparam logic [2:0] kare0 = 3'b000;
    localparam logic [2:0] kare1 = 3'b001;
    localparam logic [2:0] kare2 = 3'b010;
    localparam logic [2:0] kare3 = 3'b011;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; the seed is non-zero so it never locks up.
module game_lfsr
    import game_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    output logic [7:0] o_lfsr
);

    logic [7:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/game_round_sequencer.sv
// Round controller: sequences load/show/play/result phases, judges confirms against
// the cursor and tracks score, round and lives.
module game_round_sequencer
    import game_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES   = 25_000_000,
    parameter int unsigned PLAY_CYCLES   = 75_000_000,
    parameter int unsigned RESULT_CYCLES = 12_500_000,
    parameter int unsigned MAX_ROUNDS    = 10,
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned TIMER_W       = 27
) (
    input  logic       clk25MHz,
    input  logic       rst,
    input  logic       start,
    input  logic       confirm,
    input  logic [2:0] cursor,
    output logic [2:0] step,
    output logic [2:0] variety,
    output logic [7:0] score,
    output logic [3:0] round,
    output logic [1:0] lives,
    output logic       hit,
    output logic       game_over
);

    localparam logic [TIMER_W-1:0] SHOW_LAST   = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PLAY_LAST   = TIMER_W'(PLAY_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RESULT_LAST = TIMER_W'(RESULT_CYCLES - 1);
    localparam logic [3:0]         ROUND_LAST  = 4'(MAX_ROUNDS);
    localparam logic [1:0]         LIVES_INIT  = 2'(START_LIVES);

    logic [2:0]         r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_start_q;
    logic               r_confirm_q;
    logic [2:0]         r_variety;
    logic [7:0]         r_score;
    logic [3:0]         r_round;
    logic [1:0]         r_lives;
    logic               r_hit;
    logic               r_game_over;

    logic [7:0] w_lfsr;
    logic       w_unused_lfsr;
    logic       w_start_ev;
    logic       w_confirm_ev;
    logic [2:0] w_cand;
    logic [2:0] w_cand_next;

    game_lfsr u_lfsr (
        .i_clk  (clk25MHz),
        .i_rst  (rst),
        .o_lfsr (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[7:2];
    assign w_start_ev    = start & ~r_start_q;
    assign w_confirm_ev  = confirm & ~r_confirm_q;
    assign w_cand        = {1'b0, w_lfsr[1:0]};
    assign w_cand_next   = {1'b0, w_cand[1:0] + 2'd1};

    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_start_q   <= 1'b0;
            r_confirm_q <= 1'b0;
            r_variety   <= kare0;
            r_score     <= '0;
            r_round     <= '0;
            r_lives     <= LIVES_INIT;
            r_hit       <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_start_q   <= start;
            r_confirm_q <= confirm;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ev) begin
                        r_score <= '0;
                        r_lives <= LIVES_INIT;
                        r_round <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Bump a repeated target to the next square, except on the first round.
                    if (w_cand == r_variety && r_round != 4'd0) begin
                        r_variety <= w_cand_next;
                    end else begin
                        r_variety <= w_cand;
                    end
                    r_round <= r_round + 4'd1;
                    r_timer <= '0;
                    r_state <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (r_timer == SHOW_LAST) begin
                        r_timer <= '0;
                        r_state <= ST_PLAY;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                ST_PLAY: begin
                    // A confirm takes priority over a timeout landing on the same cycle.
                    if (w_confirm_ev) begin
                        r_timer <= '0;
                        r_state <= ST_RESULT;
                        if (cursor == r_variety) begin
                            r_hit <= 1'b1;
                            if (r_score != 8'hFF) begin
                                r_score <= r_score + 8'd1;
                            end
                        end else begin
                            r_hit <= 1'b0;
                            if (r_lives != 2'd0) begin
                                r_lives <= r_lives - 2'd1;
                            end
                        end
                    end else if (r_timer == PLAY_LAST) begin
                        r_timer <= '0;
                        r_state <= ST_RESULT;
                        r_hit   <= 1'b0;
                        if (r_lives != 2'd0) begin
                            r_lives <= r_lives - 2'd1;
                        end
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                ST_RESULT: begin
                    if (r_timer == RESULT_LAST) begin
                        r_timer <= '0;
                        if (r_lives == 2'd0 || r_round == ROUND_LAST) begin
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                ST_OVER: begin
                    if (w_start_ev) begin
                        r_game_over <= 1'b0;
                        r_score     <= '0;
                        r_lives     <= LIVES_INIT;
                        r_round     <= '0;
                        r_state     <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign step      = r_state;
    assign variety   = r_variety;
    assign score     = r_score;
    assign round     = r_round;
    assign lives     = r_lives;
    assign hit       = r_hit;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Self-checking bench for game_round_sequencer: scripted round table, randomized games
// against a round-level model, and hand-written reset / held-confirm sequences.
module tb_game_round_sequencer;

    localparam int SHOW   = 4;
    localparam int PLAY   = 8;
    localparam int RES    = 2;
    localparam int MAXR   = 3;
    localparam int LIVES0 = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       confirm = 1'b0;
    logic [2:0] cursor = 3'd0;
    logic [2:0] step;
    logic [2:0] variety;
    logic [7:0] score;
    logic [3:0] round;
    logic [1:0] lives;
    logic       hit;
    logic       game_over;

    game_round_sequencer #(
        .SHOW_CYCLES   (SHOW),
        .PLAY_CYCLES   (PLAY),
        .RESULT_CYCLES (RES),
        .MAX_ROUNDS    (MAXR),
        .START_LIVES   (LIVES0),
        .TIMER_W       (8)
    ) dut (
        .clk25MHz  (clk),
        .rst       (rst),
        .start     (start),
        .confirm   (confirm),
        .cursor    (cursor),
        .step      (step),
        .variety   (variety),
        .score     (score),
        .round     (round),
        .lives     (lives),
        .hit       (hit),
        .game_over (game_over)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: LFSR sequence position plus per-game bookkeeping.
    logic [7:0] m_lfsr;
    int         m_score;
    int         m_lives;
    int         m_round;
    logic [2:0] m_var;

    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    typedef struct {
        bit new_game;
        int act;      // 0 correct confirm, 1 wrong confirm, 2 timeout
        int d;        // PLAY cycle on which confirm rises
        int e_hit;
        int e_score;
        int e_lives;
        int e_round;
        int e_after;
    } row_t;

    row_t tab[5];
    row_t nul;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] exp_target();
        int c;
        c = int'(m_lfsr[1:0]);
        if (m_round != 0 && c == int'(m_var)) c = (c + 1) % 4;
        return 3'(c);
    endfunction

    task automatic new_game();
        if (step == 3'd5) begin
            tick();
            tick();
            check("over_hold", step, 5);
            check("over_flag", game_over, 1);
            check("over_score", score, m_score);
            check("over_lives", lives, m_lives);
            check("over_round", round, m_round);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_step", step, 1);
        check("start_score", score, 0);
        check("start_lives", lives, LIVES0);
        check("start_round", round, 0);
        check("start_over", game_over, 0);
        m_score = 0;
        m_lives = LIVES0;
        m_round = 0;
    endtask

    // Entered with step == LOAD observed; leaves after RESULT has finished.
    task automatic play_round(input int act, input int d, input logic [2:0] wx,
                              input bit use_tab, input row_t t);
        logic [2:0] ev;
        bit         eh;
        int         after;
        ev = exp_target();
        m_round++;
        tick();
        check("show_step", step, 2);
        check("show_variety", variety, ev);
        check("show_round", round, m_round);
        for (int i = 1; i < SHOW; i++) begin
            tick();
            check("show_hold", step, 2);
        end
        tick();
        check("play_step", step, 3);
        if (act == 2) begin
            for (int i = 1; i < PLAY; i++) begin
                tick();
                check("play_hold", step, 3);
            end
            tick();
            eh = 1'b0;
        end else begin
            for (int i = 0; i < d; i++) tick();
            cursor  = (act == 0) ? ev : (ev ^ wx);
            confirm = 1'b1;
            tick();
            confirm = 1'b0;
            eh = (act == 0);
        end
        check("result_step", step, 4);
        if (eh) m_score = (m_score == 255) ? 255 : m_score + 1;
        else if (m_lives > 0) m_lives--;
        check("result_hit", hit, eh);
        check("result_score", score, m_score);
        check("result_lives", lives, m_lives);
        check("result_round", round, m_round);
        if (use_tab) begin
            check("tab_hit", hit, t.e_hit);
            check("tab_score", score, t.e_score);
            check("tab_lives", lives, t.e_lives);
            check("tab_round", round, t.e_round);
        end
        tick();
        check("result_hold", step, 4);
        tick();
        after = (m_lives == 0 || m_round == MAXR) ? 5 : 1;
        check("after_step", step, after);
        check("after_over", game_over, after == 5);
        if (use_tab) check("tab_after", step, t.e_after);
        m_var = ev;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] ev;
        //         new  act d  hit sc lv rd after
        tab[0] = '{1,   1,  0, 0,  0, 1, 1, 1};
        tab[1] = '{0,   2,  0, 0,  0, 0, 2, 5};
        tab[2] = '{1,   0,  1, 1,  1, 2, 1, 1};
        tab[3] = '{0,   0,  7, 1,  2, 2, 2, 1};
        tab[4] = '{0,   0,  4, 1,  3, 2, 3, 5};
        nul    = '{0, 0, 0, 0, 0, 0, 0, 0};

        rst = 1'b1;
        tick();
        tick();
        check("rst_step", step, 0);
        check("rst_variety", variety, 0);
        check("rst_score", score, 0);
        check("rst_round", round, 0);
        check("rst_lives", lives, LIVES0);
        check("rst_hit", hit, 0);
        check("rst_over", game_over, 0);
        rst = 1'b0;
        m_var = 3'd0;
        tick();
        tick();
        check("idle_hold", step, 0);
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        check("idle_confirm_ignored", step, 0);

        for (int i = 0; i < 5; i++) begin
            if (tab[i].new_game) new_game();
            play_round(tab[i].act, tab[i].d, 3'd1, 1'b1, tab[i]);
        end

        for (int g = 0; g < 6; g++) begin
            new_game();
            for (int r = 0; r < MAXR && step == 3'd1; r++) begin
                play_round(int'($urandom_range(0, 2)), int'($urandom_range(0, PLAY - 1)),
                           3'($urandom_range(1, 7)), 1'b0, nul);
            end
            check("rand_game_end", step, 5);
        end

        // Reset in the middle of PLAY with score 2.
        new_game();
        play_round(0, 0, 3'd1, 1'b0, nul);
        play_round(0, 3, 3'd1, 1'b0, nul);
        for (int i = 0; i < SHOW + 1; i++) tick();
        check("pre_rst_step", step, 3);
        check("pre_rst_score", score, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_step", step, 0);
        check("midrst_score", score, 0);
        check("midrst_round", round, 0);
        check("midrst_lives", lives, LIVES0);
        check("midrst_variety", variety, 0);
        check("midrst_over", game_over, 0);
        m_score = 0;
        m_lives = LIVES0;
        m_round = 0;
        m_var   = 3'd0;

        // Confirm held from before the game, plus a start pulse during SHOW.
        confirm = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("held_load", step, 1);
        ev = exp_target();
        m_round = 1;
        tick();
        check("held_show", step, 2);
        check("held_variety", variety, ev);
        cursor = ev;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("show_start_ignored", step, 2);
        check("show_start_round", round, 1);
        tick();
        tick();
        tick();
        check("held_play", step, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_no_judge", step, 3);
        end
        confirm = 1'b0;
        tick();
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        check("repress_step", step, 4);
        check("repress_hit", hit, 1);
        check("repress_score", score, 1);
        check("repress_lives", lives, LIVES0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
